// File: rtl/clk_div_chk_pkg.sv
// Shared types and helpers for the divided-clock ratio checker.
package clk_div_chk_pkg;

    localparam int CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACQ,
        S_LOCK
    } state_t;

    // Increment that sticks at max instead of wrapping.
    function automatic int unsigned sat_inc(input int unsigned value, input int unsigned max);
        return (value >= max) ? max : value + 1;
    endfunction

endpackage

// File: rtl/clk_period_meter.sv
// Samples the divided clock, detects its rising edges and measures
// rise-to-rise period and high time in source-clock cycles.
module clk_period_meter
    import clk_div_chk_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             div_in,
    output logic             rise,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             in_q;
    logic             in_q_d;
    logic [CNT_W-1:0] per_cnt;
    logic [CNT_W-1:0] hi_acc;

    assign rise   = in_q & ~in_q_d;
    assign period = CNT_W'(sat_inc(32'(per_cnt), 32'(CNT_MAX)));
    assign high   = hi_acc;

    // The sample taken on the rising-edge cycle is already high, so hi_acc restarts at 1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_q    <= 1'b0;
            in_q_d  <= 1'b0;
            per_cnt <= '0;
            hi_acc  <= '0;
        end else begin
            in_q   <= div_in;
            in_q_d <= in_q;
            if (clr) begin
                per_cnt <= '0;
                hi_acc  <= '0;
            end else if (rise) begin
                per_cnt <= '0;
                hi_acc  <= CNT_W'(1);
            end else begin
                per_cnt <= CNT_W'(sat_inc(32'(per_cnt), 32'(CNT_MAX)));
                if (in_q) begin
                    hi_acc <= CNT_W'(sat_inc(32'(hi_acc), 32'(CNT_MAX)));
                end
            end
        end
    end

endmodule

// File: rtl/clk_div_ratio_checker.sv
// Checks a divided clock against an expected ratio and reports
// measurements, lock, mismatch errors and stalls.
module clk_div_ratio_checker
    import clk_div_chk_pkg::*;
#(
    parameter int CNT_W      = CNT_W_DEF,
    parameter int EXP_PERIOD = 3,
    parameter int LOCK_CNT   = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             div_in,
    input  logic             err_clr,
    output logic [CNT_W-1:0] meas_period,
    output logic [CNT_W-1:0] meas_high,
    output logic             meas_valid,
    output logic             locked,
    output logic             err_pulse,
    output logic             err_sticky,
    output logic             stall
);

    state_t           state;
    logic [3:0]       match_cnt;
    logic [3:0]       match_next;
    logic             rise;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high;
    logic             period_ok;
    logic             timeout_hit;
    logic             set_err;

    clk_period_meter #(
        .CNT_W(CNT_W)
    ) u_meter (
        .clk   (clk),
        .reset (reset),
        .clr   (~en),
        .div_in(div_in),
        .rise  (rise),
        .period(period),
        .high  (high)
    );

    // period is per_cnt+1, so reaching TIMEOUT here means per_cnt == TIMEOUT-1.
    assign period_ok   = (period == CNT_W'(EXP_PERIOD));
    assign timeout_hit = (period == CNT_W'(TIMEOUT));
    assign match_next  = match_cnt + 4'd1;
    assign set_err     = en && (state == S_LOCK) &&
                         ((rise && !period_ok) || (!rise && timeout_hit));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            match_cnt   <= '0;
            meas_period <= '0;
            meas_high   <= '0;
            meas_valid  <= 1'b0;
            locked      <= 1'b0;
            err_pulse   <= 1'b0;
            err_sticky  <= 1'b0;
            stall       <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            err_pulse  <= 1'b0;
            stall      <= 1'b0;

            if (set_err) begin
                err_sticky <= 1'b1;
            end else if (err_clr) begin
                err_sticky <= 1'b0;
            end

            if (!en) begin
                state     <= S_IDLE;
                match_cnt <= '0;
                locked    <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (rise) begin
                            state     <= S_ACQ;
                            match_cnt <= '0;
                        end
                    end
                    S_ACQ, S_LOCK: begin
                        if (rise) begin
                            meas_period <= period;
                            meas_high   <= high;
                            meas_valid  <= 1'b1;
                            if (state == S_ACQ) begin
                                if (period_ok) begin
                                    match_cnt <= match_next;
                                    if (match_next == 4'(LOCK_CNT)) begin
                                        state  <= S_LOCK;
                                        locked <= 1'b1;
                                    end
                                end else begin
                                    match_cnt <= '0;
                                end
                            end else if (!period_ok) begin
                                err_pulse <= 1'b1;
                                locked    <= 1'b0;
                                state     <= S_ACQ;
                                match_cnt <= '0;
                            end
                        end else if (timeout_hit) begin
                            stall     <= 1'b1;
                            state     <= S_IDLE;
                            locked    <= 1'b0;
                            match_cnt <= '0;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_clk_div_ratio_checker.sv
// Self-checking bench: a vector table for the initial lock, directed corner
// sequences and random waveforms compared against a timestamp-based reference model.
module tb_clk_div_ratio_checker;

    localparam int CNT_W = 8;
    localparam int EXP   = 3;
    localparam int LOCKN = 4;
    localparam int TMO   = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             en;
    logic             div_in;
    logic             err_clr;
    logic [CNT_W-1:0] meas_period;
    logic [CNT_W-1:0] meas_high;
    logic             meas_valid;
    logic             locked;
    logic             err_pulse;
    logic             err_sticky;
    logic             stall;

    always #5 clk = ~clk;

    clk_div_ratio_checker #(
        .CNT_W     (CNT_W),
        .EXP_PERIOD(EXP),
        .LOCK_CNT  (LOCKN),
        .TIMEOUT   (TMO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .div_in     (div_in),
        .err_clr    (err_clr),
        .meas_period(meas_period),
        .meas_high  (meas_high),
        .meas_valid (meas_valid),
        .locked     (locked),
        .err_pulse  (err_pulse),
        .err_sticky (err_sticky),
        .stall      (stall)
    );

    typedef struct {
        bit en;
        bit div;
        bit clr;
        bit exp_valid;
        bit exp_locked;
        int exp_period;
        int exp_high;
    } vec_t;

    vec_t tbl[18];

    int errors = 0;
    int checks = 0;
    int vcount = 0;

    // Reference model: div_in history indexed by clock edge, rise timestamps.
    int dbuf[0:8191];
    int p    = 0;
    int base = 1;
    int lr   = 0;
    int m_state, m_match, m_period, m_high;
    bit m_locked, m_sticky, m_valid, m_err, m_stall;

    function automatic int get_d(input int idx);
        return (idx < base) ? 0 : dbuf[idx];
    endfunction

    task automatic model_reset();
        m_state  = 0;
        m_match  = 0;
        m_period = 0;
        m_high   = 0;
        m_locked = 0;
        m_sticky = 0;
        m_valid  = 0;
        m_err    = 0;
        m_stall  = 0;
        lr       = 0;
    endtask

    task automatic model_step(input bit e, input bit c);
        bit rs;
        bit set_e;
        int el;
        int hs;
        rs      = (get_d(p - 1) == 1) && (get_d(p - 2) == 0);
        el      = (p - 1) - lr;
        m_valid = 0;
        m_err   = 0;
        m_stall = 0;
        set_e   = 0;
        if (!e) begin
            m_state  = 0;
            m_match  = 0;
            m_locked = 0;
        end else if (m_state == 0) begin
            if (rs) begin
                m_state = 1;
                m_match = 0;
            end
        end else if (rs) begin
            hs = 0;
            for (int k = lr; k <= p - 2; k++) hs += get_d(k);
            m_period = (el > 255) ? 255 : el;
            m_high   = (hs > 255) ? 255 : hs;
            m_valid  = 1;
            if (m_state == 1) begin
                if (m_period == EXP) begin
                    m_match++;
                    if (m_match == LOCKN) begin
                        m_state  = 2;
                        m_locked = 1;
                    end
                end else begin
                    m_match = 0;
                end
            end else if (m_period != EXP) begin
                m_err    = 1;
                set_e    = 1;
                m_locked = 0;
                m_state  = 1;
                m_match  = 0;
            end
        end else if (el == TMO) begin
            m_stall = 1;
            if (m_state == 2) set_e = 1;
            m_state  = 0;
            m_locked = 0;
            m_match  = 0;
        end
        if (set_e) m_sticky = 1;
        else if (c) m_sticky = 0;
        if (rs) lr = p - 1;
    endtask

    task automatic check_val(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d (edge %0d, t=%0t)", name, act, exp, p, $time);
        end
    endtask

    task automatic check_output();
        check_val("meas_period", int'(meas_period), m_period);
        check_val("meas_high",   int'(meas_high),   m_high);
        check_val("meas_valid",  int'(meas_valid),  int'(m_valid));
        check_val("locked",      int'(locked),      int'(m_locked));
        check_val("err_pulse",   int'(err_pulse),   int'(m_err));
        check_val("err_sticky",  int'(err_sticky),  int'(m_sticky));
        check_val("stall",       int'(stall),       int'(m_stall));
        if (meas_valid) vcount++;
    endtask

    // Drive one cycle from a negedge, advance the model at the posedge, compare at the next negedge.
    task automatic apply_stimulus(input bit e, input bit d, input bit c);
        en      = e;
        div_in  = d;
        err_clr = c;
        @(posedge clk);
        p++;
        dbuf[p] = int'(d);
        model_step(e, c);
        @(negedge clk);
        check_output();
    endtask

    task automatic run_shape(input int len, input int hi, input int clr_step, input bit e);
        for (int k = 0; k < len; k++)
            apply_stimulus(e, (k >= 1) && (k <= hi), k == clr_step);
    endtask

    task automatic run_period(input int len, input int clr_step, input bit e);
        run_shape(len, 1, clr_step, e);
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_period"}, int'(meas_period), 0);
        check_val({tag, "_high"},   int'(meas_high),   0);
        check_val({tag, "_valid"},  int'(meas_valid),  0);
        check_val({tag, "_locked"}, int'(locked),      0);
        check_val({tag, "_errp"},   int'(err_pulse),   0);
        check_val({tag, "_sticky"}, int'(err_sticky),  0);
        check_val({tag, "_stall"},  int'(stall),       0);
    endtask

    initial begin
        int v0;
        int stall_cnt;
        int stall_at;
        int len;
        int hi;

        // Ideal divide-by-3 after reset: first rise only arms, captures every 3rd cycle, lock on the 4th.
        for (int i = 0; i < 18; i++) begin
            tbl[i].en         = 1'b1;
            tbl[i].div        = (i % 3 == 1);
            tbl[i].clr        = 1'b0;
            tbl[i].exp_valid  = (i >= 5) && (i % 3 == 2);
            tbl[i].exp_locked = (i >= 14);
            tbl[i].exp_period = (i >= 5) ? 3 : 0;
            tbl[i].exp_high   = (i >= 5) ? 1 : 0;
        end

        reset   = 1'b0;
        en      = 1'b0;
        div_in  = 1'b0;
        err_clr = 1'b0;
        model_reset();
        #1 reset = 1'b1;
        #1 check_all_zero("reset");
        @(negedge clk);
        reset = 1'b0;
        base  = p + 1;

        for (int i = 0; i < 18; i++) begin
            apply_stimulus(tbl[i].en, tbl[i].div, tbl[i].clr);
            check_val("tbl_valid",  int'(meas_valid),  int'(tbl[i].exp_valid));
            check_val("tbl_locked", int'(locked),      int'(tbl[i].exp_locked));
            check_val("tbl_period", int'(meas_period), tbl[i].exp_period);
            check_val("tbl_high",   int'(meas_high),   tbl[i].exp_high);
            check_val("tbl_sticky", int'(err_sticky),  0);
        end

        // Glitch while locked: one 4-cycle period.
        run_period(3, -1, 1'b1);
        run_period(4, -1, 1'b1);
        run_period(3, -1, 1'b1);
        check_val("glitch_period", int'(meas_period), 4);
        check_val("glitch_errp",   int'(err_pulse),   1);
        check_val("glitch_sticky", int'(err_sticky),  1);
        check_val("glitch_locked", int'(locked),      0);
        for (int i = 0; i < 3; i++) run_period(3, -1, 1'b1);
        check_val("relock_early", int'(locked), 0);
        run_period(3, -1, 1'b1);
        check_val("relock", int'(locked), 1);

        run_period(3, 0, 1'b1);
        check_val("clr_alone", int'(err_sticky), 0);

        // Clear in the same cycle as the error pulse, then one cycle later.
        run_period(4, -1, 1'b1);
        run_period(3, 2, 1'b1);
        check_val("collide_errp",   int'(err_pulse),  1);
        check_val("collide_sticky", int'(err_sticky), 1);
        run_period(3, 0, 1'b1);
        check_val("clr_after", int'(err_sticky), 0);
        for (int i = 0; i < 4; i++) run_period(3, -1, 1'b1);
        check_val("relock2", int'(locked), 1);

        // Stall: hold low after lock; the last high sample was two cycles before the hold.
        stall_cnt = 0;
        stall_at  = -1;
        for (int j = 0; j < 30; j++) begin
            apply_stimulus(1'b1, 1'b0, 1'b0);
            if (stall) begin
                stall_cnt++;
                if (stall_at < 0) stall_at = j;
            end
        end
        check_val("stall_count",  stall_cnt, 1);
        check_val("stall_at",     stall_at, 15);
        check_val("stall_sticky", int'(err_sticky), 1);
        check_val("stall_locked", int'(locked), 0);

        v0 = vcount;
        run_period(3, -1, 1'b1);
        check_val("resume_first_novalid", vcount - v0, 0);
        run_period(3, -1, 1'b1);
        check_val("resume_capture", vcount - v0, 1);
        check_val("resume_period", int'(meas_period), 3);
        for (int i = 0; i < 3; i++) run_period(3, -1, 1'b1);
        check_val("resume_locked", int'(locked), 1);

        // Asynchronous reset between edges while locked.
        #2 reset = 1'b1;
        #1 check_all_zero("midreset");
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        base = p + 1;
        for (int i = 0; i < 4; i++) run_period(3, -1, 1'b1);
        check_val("reset_lock_early", int'(locked), 0);
        run_period(3, -1, 1'b1);
        check_val("reset_lock", int'(locked), 1);

        // Enable gating for 5 cycles while the waveform keeps running.
        for (int k = 0; k < 5; k++) begin
            apply_stimulus(1'b0, k % 3 == 1, 1'b0);
            if (k == 0) check_val("en_locked", int'(locked), 0);
        end
        check_val("en_hold_period", int'(meas_period), 3);
        check_val("en_hold_high",   int'(meas_high),   1);
        v0 = vcount;
        apply_stimulus(1'b1, 1'b0, 1'b0);
        check_val("en_first_novalid", vcount - v0, 0);
        run_period(3, -1, 1'b1);
        check_val("en_capture", vcount - v0, 1);
        for (int i = 0; i < 3; i++) run_period(3, -1, 1'b1);
        check_val("en_relock", int'(locked), 1);

        // Random periods, high times, enable drops and clears.
        for (int r = 0; r < 70; r++) begin
            if ($urandom_range(0, 1) == 0) begin
                len = EXP;
                hi  = 1;
            end else begin
                len = $urandom_range(2, 20);
                hi  = $urandom_range(1, len - 1);
            end
            run_shape(len, hi,
                      ($urandom_range(0, 7) == 0) ? $urandom_range(0, len - 1) : -1,
                      $urandom_range(0, 15) != 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/clk_div_ratio_checker.md
Name: clk_div_ratio_checker

Overview:
Monitor for divided clocks produced by the team's frequency dividers, such as the divide-by-3 output. It samples a slow divided-clock signal in the source clock domain and measures each period and its high time in source-clock cycles. It checks the period against an expected ratio and reports lock, mismatch errors and stalls. It sits beside a divider as a built-in self-check and status source.

Parameters:
CNT_W, 8, width of the period and high-time counters and measurement outputs
EXP_PERIOD, 3, expected divide ratio in clk cycles (2..2^CNT_W-1)
LOCK_CNT, 4, consecutive matching periods required to assert locked (1..15)
TIMEOUT, 16, cycles without a rising edge before a stall is declared (must exceed EXP_PERIOD, at most 2^CNT_W-1)

Ports:
clk  input  1  source clock; the divider runs on the same clock
reset  input  1  asynchronous, active-high reset
en  input  1  checker enable; 0 forces IDLE and clears the counters
div_in  input  1  divided-clock signal under test, synchronous to clk
err_clr  input  1  clears err_sticky
meas_period  output  CNT_W  last measured period (rising edge to rising edge)
meas_high  output  CNT_W  high cycles within the last measured period
meas_valid  output  1  one-cycle pulse when meas_period and meas_high update
locked  output  1  ratio matched for LOCK_CNT consecutive periods
err_pulse  output  1  one-cycle pulse on a period mismatch while locked
err_sticky  output  1  latched mismatch flag
stall  output  1  one-cycle pulse when TIMEOUT is reached with no edge

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous and active-high. It clears every register, so all outputs are 0 and the FSM is in IDLE. Reset mid-measurement discards any partial count.
- Input sampling: in_q <= div_in. rise = in_q & ~in_q_d, where in_q_d is in_q delayed by one cycle. The rise is seen 2 cycles after div_in rises.
- Period counter per_cnt:
  - On rise: per_cnt <= 0.
  - Otherwise: per_cnt <= per_cnt+1, saturating at 2^CNT_W-1.
  - Captured period = per_cnt+1, saturated.
- High-time accumulator hi_acc:
  - On rise: hi_acc <= 1.
  - Otherwise: hi_acc <= hi_acc + in_q, saturating.
  - Captured high time = hi_acc.
- Capture: on a rise while the state is ACQ or LOCK, register the period and high time into meas_period/meas_high and pulse meas_valid in the following cycle. The first rise after IDLE only starts counting; it produces no meas_valid.
- FSM states (S_IDLE, S_ACQ, S_LOCK):
  - IDLE -> ACQ on rise with en=1. match_cnt <= 0.
  - ACQ, on capture:
    - If period == EXP_PERIOD: match_cnt++. When match_cnt reaches LOCK_CNT, go to LOCK and assert locked in the same cycle as meas_valid.
    - On mismatch: match_cnt <= 0 and stay in ACQ. No error is raised before lock.
  - LOCK, on capture with a mismatch: pulse err_pulse, set err_sticky, deassert locked, go to ACQ, match_cnt <= 0.
  - ACQ or LOCK with per_cnt == TIMEOUT-1 and no rise: pulse stall once, go to IDLE, deassert locked.
    - A stall raised from LOCK also sets err_sticky.
  - en=0 in any state: go to IDLE next cycle, clear the counters and match_cnt, deassert locked. meas_period/meas_high hold their last values. err_sticky holds.
- err_sticky: if err_clr and a new error occur in the same cycle, set wins. err_clr alone clears err_sticky next cycle.
- Pulse outputs (meas_valid, err_pulse, stall) are registered and last exactly 1 cycle.
- A saturated period (div_in stuck, then recovering) always counts as a mismatch.

Decomposition:
- Package clk_div_chk_pkg holds:
  - the state enum (S_IDLE, S_ACQ, S_LOCK);
  - CNT_W default;
  - a saturating-increment function.
- Sub-module clk_period_meter contains the sampling flop, edge detect, per_cnt and hi_acc. It outputs rise, period and high. The top level holds the FSM, the capture registers and the flags.

Test Plan:
- Lock on a divide-by-3 stimulus: drive an ideal div-by-3 pattern (0,1,0 repeating), en=1 -> meas_valid every 3 cycles with meas_period=3 and meas_high=1. locked rises with the 4th meas_valid. err_sticky=0.
- Glitch while locked: after lock, insert one period of 4 cycles -> that capture shows meas_period=4, err_pulse for 1 cycle, err_sticky=1, locked=0. Locked reasserts after 4 further period-3 captures.
- Stall and recovery: hold div_in=0 after lock -> stall pulses exactly once, 16 cycles after the last rise, state is IDLE, err_sticky=1. Resume div-by-3 -> the first rise gives no meas_valid and the following rises capture 3.
- Clear collision: assert err_clr in the same cycle as err_pulse -> err_sticky stays 1. err_clr one cycle later -> err_sticky=0.
- Reset mid-period: assert reset asynchronously between clock edges while locked -> all outputs are 0 immediately. After release and stimulus, lock takes the full LOCK_CNT again.
- en gating: drop en for 5 cycles while locked -> locked=0 the next cycle and meas values held. Re-enable -> no meas_valid on the first rise, then normal captures.
